instr_assembler: RTL and testbench
==================================

# instr_assembler

Parametrised successor to the fixed 8-bit opcode + 16-bit immediate instruction register in the control unit. Collects instruction bytes from the memory interface one `mem_ack` at a time and decodes the immediate length from the opcode itself. Completed instructions are queued in a small FIFO, so fetch can run ahead of the decoder. Sits between the memory arbiter and the control-unit decoder.

## Interface
- `BUS_W`, 8, width of the memory data bus, the opcode and each immediate byte
- `IMM_BYTES`, 2, maximum immediate length in bus words; legal range 1..3
- `DEPTH`, 2, completed-instruction FIFO entries; legal values are powers of two ≥2
- `clk`  in  1  system clock; all state updates on its rising edge
- `nrst`  in  1  reset; one clock; reset is synchronous and active-low
- `data`  in  BUS_W  memory read data; valid when `mem_ack`=1
- `mem_ack`  in  1  memory strobe, one byte per asserted cycle
- `hold`  in  1  stall; blocks byte acceptance but not `consume`
- `clear`  in  1  synchronous flush of assembly state and FIFO
- `consume`  in  1  decoder pops the head instruction
- `fetch_req`  out  1  block can accept a byte this cycle
- `instr_valid`  out  1  FIFO non-empty
- `opcode_o`  out  BUS_W  head opcode
- `immediate`  out  IMM_BYTES*BUS_W  head immediate; little-endian, unused upper bytes 0
- `imm_len`  out  2  head immediate length in bytes
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Byte accepted at a rising edge iff `mem_ack` & `fetch_req`; `mem_ack` while `fetch_req`=0 is ignored, with no state change.
- `fetch_req` = `nrst` & !`hold` & !`clear` & (`count` < DEPTH); combinational.
- Internal byte index `idx` (width $clog2(IMM_BYTES+1)), probeable by the bench:
  - 0 means awaiting the opcode.
  - k>0 means awaiting immediate byte k-1.
- Length decode: `len` = min(opcode[BUS_W-1:BUS_W-2], IMM_BYTES); latched with the opcode.
- On each accepted byte:
  - idx=0: latch opcode and len; zero the assembly immediate.
  - idx=k: write the byte to immediate slice k-1.
- Completion is the accepted byte that makes the byte total len+1. On the same edge, push {opcode, imm, len} into the FIFO and return `idx` to 0. A len=0 opcode completes on its own byte.
- Otherwise `idx` increments on each accepted byte.
- Pop: `consume` & `instr_valid` advances the head at the edge. `consume` while empty is ignored.
- Simultaneous push and pop: `count` unchanged, head advances, new entry lands at the tail.
- Push is guaranteed legal because `fetch_req` is 0 when full. Partial assembly may proceed while `count`<DEPTH.
- Priority, highest first: `nrst`=0, then `clear`, then normal operation. `clear` zeroes `idx`, the FIFO pointers and `count`; byte and `consume` that cycle are discarded.
- Head outputs read 0 when `instr_valid`=0.

## Timing
- Reset (`nrst` low at an edge): `idx`=0, `count`=0, FIFO pointers 0, all entry storage 0.
- Reset values of outputs: `instr_valid`=0, `opcode_o`=0, `immediate`=0, `imm_len`=0, `fetch_req`=0 while `nrst`=0.
- Reset mid-instruction discards the partial instruction and all queued entries.
- Latency: last byte accepted at edge N, so `instr_valid`/`count` update after edge N, visible by N+1 sampling.
- Head outputs are driven from registered FIFO storage indexed by the registered read pointer; no combinational path from `data`.
- Pointer wrap: log2(DEPTH)-bit pointers wrap modulo DEPTH; `count` disambiguates full from empty.
- `hold` freezes `idx` and the assembly registers indefinitely; resuming continues at the same byte position.

## Test plan
Defaults BUS_W=8, IMM_BYTES=2, DEPTH=2.
- Reset: `nrst`=0 for 2 cycles with `mem_ack`=1, `data`=0xFF → all outputs 0, `idx`=0; after release `fetch_req`=1.
- Lengths: feed 0x12 → `imm_len`=0, imm 0x0000. Feed 0x45,0x21 → len 1, imm 0x0021. Feed 0x83,0x21,0x15 → len 2, imm 0x1521. Feed 0xC7,0xAA,0xBB → len clamps to 2, imm 0xBBAA, next 0x12 is a new opcode. Pop each entry and check it in order.
- Hold/gaps: 0x83, idle 5 cycles, 0x21, `hold`=1 with `mem_ack`=1 `data`=0x24 for 3 cycles, release, 0x15 → imm 0x1521, `idx` held at 2 during hold.
- Full/backpressure: push 0x12 twice without `consume` → `count`=2, `fetch_req`=0, 0x45 ignored. Then `consume` and ack 0x45 in the same cycle → byte dropped (fetch_req was 0), `count`=1.
- Simultaneous push/pop: `count`=1, `consume`=1 with last byte of 0x45,0x33 → `count` stays 1, head = 0x45/0x0033.
- Clear/flush: after 0x83,0x21 with one entry queued, pulse `clear` with `mem_ack`=1 `data`=0x15 → `count`=0, `idx`=0, `instr_valid`=0; next byte 0x12 is treated as an opcode.

Source files
------------

// File: rtl/instr_assembler.sv
// Variable-length instruction assembler: gathers an opcode plus 0..IMM_BYTES immediate
// bytes from the memory bus and queues completed instructions in a small FIFO.
module instr_assembler #(
  parameter int BUS_W     = 8,
  parameter int IMM_BYTES = 2,
  parameter int DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [BUS_W-1:0]             data,
  input  logic                         mem_ack,
  input  logic                         hold,
  input  logic                         clear,
  input  logic                         consume,
  output logic                         fetch_req,
  output logic                         instr_valid,
  output logic [BUS_W-1:0]             opcode_o,
  output logic [IMM_BYTES*BUS_W-1:0]   immediate,
  output logic [1:0]                   imm_len,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IMM_W = IMM_BYTES * BUS_W;
  localparam int IDX_W = $clog2(IMM_BYTES + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [1:0]       MAX_LEN = 2'(IMM_BYTES);

  logic [IDX_W-1:0] r_idx;
  logic [BUS_W-1:0] r_opcode;
  logic [IMM_W-1:0] r_imm;
  logic [1:0]       r_len;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [BUS_W-1:0] r_fifo_op  [DEPTH];
  logic [IMM_W-1:0] r_fifo_imm [DEPTH];
  logic [1:0]       r_fifo_len [DEPTH];

  logic             w_accept;
  logic             w_pop;
  logic             w_done;
  logic [1:0]       w_dec_len;
  logic [1:0]       w_len_now;
  logic [BUS_W-1:0] w_op_now;
  logic [IMM_W-1:0] w_imm_next;

  // fetch_req already folds in reset, clear and FIFO-full, so accept is safe to push
  assign fetch_req   = nrst & ~hold & ~clear & (r_count < DEPTH_C);
  assign w_accept    = mem_ack & fetch_req;
  assign instr_valid = (r_count != '0);
  assign w_pop       = consume & instr_valid;
  assign count       = r_count;

  assign w_dec_len = (data[BUS_W-1 -: 2] > MAX_LEN) ? MAX_LEN : data[BUS_W-1 -: 2];
  assign w_len_now = (r_idx == '0) ? w_dec_len : r_len;
  assign w_op_now  = (r_idx == '0) ? data : r_opcode;
  assign w_done    = w_accept && (r_idx == IDX_W'(w_len_now));

  always_comb begin
    w_imm_next = r_imm;
    if (r_idx == '0) begin
      w_imm_next = '0;
    end else begin
      for (int i = 0; i < IMM_BYTES; i++) begin
        if (r_idx == IDX_W'(i + 1)) w_imm_next[i*BUS_W +: BUS_W] = data;
      end
    end
  end

  assign opcode_o  = instr_valid ? r_fifo_op[r_rd_ptr]  : '0;
  assign immediate = instr_valid ? r_fifo_imm[r_rd_ptr] : '0;
  assign imm_len   = instr_valid ? r_fifo_len[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_idx    <= '0;
      r_opcode <= '0;
      r_imm    <= '0;
      r_len    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_op[i]  <= '0;
        r_fifo_imm[i] <= '0;
        r_fifo_len[i] <= '0;
      end
    end else if (clear) begin
      r_idx    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        if (r_idx == '0) begin
          r_opcode <= data;
          r_len    <= w_dec_len;
        end
        r_imm <= w_imm_next;
        if (w_done) begin
          r_idx                <= '0;
          r_fifo_op[r_wr_ptr]  <= w_op_now;
          r_fifo_imm[r_wr_ptr] <= w_imm_next;
          r_fifo_len[r_wr_ptr] <= w_len_now;
          r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_done, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: table of single-instruction vectors plus
// hand-written hold, backpressure, push/pop and flush sequences.
module tb_instr_assembler;
  localparam int BUS_W     = 8;
  localparam int IMM_BYTES = 2;
  localparam int DEPTH     = 2;
  localparam int IMM_W     = IMM_BYTES * BUS_W;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int ENT_W     = BUS_W + IMM_W + 2;

  logic             clk = 1'b0;
  logic             nrst;
  logic [BUS_W-1:0] data;
  logic             mem_ack;
  logic             hold;
  logic             clear;
  logic             consume;
  logic             fetch_req;
  logic             instr_valid;
  logic [BUS_W-1:0] opcode_o;
  logic [IMM_W-1:0] immediate;
  logic [1:0]       imm_len;
  logic [CNT_W-1:0] count;

  instr_assembler #(.BUS_W(BUS_W), .IMM_BYTES(IMM_BYTES), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .data(data), .mem_ack(mem_ack), .hold(hold),
    .clear(clear), .consume(consume), .fetch_req(fetch_req),
    .instr_valid(instr_valid), .opcode_o(opcode_o), .immediate(immediate),
    .imm_len(imm_len), .count(count)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [ENT_W-1:0] exp_q[$];

  typedef struct {
    int          n;
    logic [23:0] bytes;
    logic [7:0]  op;
    logic [15:0] imm;
    logic [1:0]  len;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock of stimulus, inputs return to idle just after the edge
  task automatic cycle(input logic a, input logic [7:0] d, input logic c);
    mem_ack = a;
    data    = d;
    consume = c;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    data    = '0;
    consume = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [15:0] imm, input logic [1:0] len);
    exp_q.push_back({op, imm, len});
  endtask

  // scoreboard: head must match the oldest expected entry, then pop it
  task automatic pop_check(input string name, input logic a, input logic [7:0] d);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: pop with empty expected queue", name);
    end else begin
      check(name, 32'({opcode_o, immediate, imm_len}), 32'(exp_q.pop_front()));
    end
    cycle(a, d, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1, 24'h000012, 8'h12, 16'h0000, 2'd0};
    vecs[1] = '{2, 24'h002145, 8'h45, 16'h0021, 2'd1};
    vecs[2] = '{3, 24'h152183, 8'h83, 16'h1521, 2'd2};
    vecs[3] = '{3, 24'hBBAAC7, 8'hC7, 16'hBBAA, 2'd2};
    vecs[4] = '{1, 24'h000012, 8'h12, 16'h0000, 2'd0};
    vecs[5] = '{2, 24'h009C7F, 8'h7F, 16'h009C, 2'd1};

    // reset with bus activity
    nrst = 1'b0; hold = 1'b0; clear = 1'b0; consume = 1'b0;
    mem_ack = 1'b1; data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fetch_req", 32'(fetch_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_opcode", 32'(opcode_o), 0);
    check("rst_imm", 32'(immediate), 0);
    check("rst_len", 32'(imm_len), 0);
    check("rst_count", 32'(count), 0);
    check("rst_idx", 32'(dut.r_idx), 0);
    nrst = 1'b1; mem_ack = 1'b0; data = '0;
    #1;
    check("rel_fetch_req", 32'(fetch_req), 1);
    @(posedge clk);
    #1;

    // table: one instruction at a time
    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < vecs[v].n; j++) begin
        send(vecs[v].bytes[j*8 +: 8]);
        if (j < vecs[v].n - 1) check($sformatf("v%0d_idx%0d", v, j), 32'(dut.r_idx), 32'(j + 1));
      end
      push_exp(vecs[v].op, vecs[v].imm, vecs[v].len);
      check($sformatf("v%0d_count", v), 32'(count), 1);
      check($sformatf("v%0d_idx_done", v), 32'(dut.r_idx), 0);
      pop_check($sformatf("v%0d_head", v), 1'b0, 8'h00);
      check($sformatf("v%0d_empty", v), 32'(instr_valid), 0);
    end

    // gaps and hold
    send(8'h83);
    cycle(1'b0, 8'h00, 1'b0); cycle(1'b0, 8'h00, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0); cycle(1'b0, 8'h00, 1'b0);
    check("gap_idx", 32'(dut.r_idx), 1);
    send(8'h21);
    hold = 1'b1; mem_ack = 1'b1; data = 8'h24;
    #1;
    check("hold_fetch_req", 32'(fetch_req), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_idx%0d", k), 32'(dut.r_idx), 2);
    end
    hold = 1'b0; mem_ack = 1'b0; data = '0;
    check("hold_count", 32'(count), 0);
    send(8'h15);
    push_exp(8'h83, 16'h1521, 2'd2);
    pop_check("hold_head", 1'b0, 8'h00);

    // full FIFO backpressure
    send(8'h12); push_exp(8'h12, 16'h0000, 2'd0);
    send(8'h12); push_exp(8'h12, 16'h0000, 2'd0);
    check("full_count", 32'(count), 2);
    check("full_fetch_req", 32'(fetch_req), 0);
    cycle(1'b1, 8'h45, 1'b0);
    check("full_ign_count", 32'(count), 2);
    check("full_ign_idx", 32'(dut.r_idx), 0);
    pop_check("full_pop_head", 1'b1, 8'h45);
    check("full_pop_count", 32'(count), 1);
    check("full_pop_idx", 32'(dut.r_idx), 0);

    // push and pop on the same edge
    send(8'h45);
    check("pp_idx", 32'(dut.r_idx), 1);
    push_exp(8'h45, 16'h0033, 2'd1);
    pop_check("pp_old_head", 1'b1, 8'h33);
    check("pp_count", 32'(count), 1);
    pop_check("pp_new_head", 1'b0, 8'h00);
    check("pp_count_after", 32'(count), 0);

    // flush mid-instruction with an entry queued
    send(8'h12); push_exp(8'h12, 16'h0000, 2'd0);
    send(8'h83);
    send(8'h21);
    check("clr_pre_idx", 32'(dut.r_idx), 2);
    check("clr_pre_count", 32'(count), 1);
    clear = 1'b1; mem_ack = 1'b1; data = 8'h15;
    #1;
    check("clr_fetch_req", 32'(fetch_req), 0);
    @(posedge clk);
    #1;
    clear = 1'b0; mem_ack = 1'b0; data = '0;
    exp_q.delete();
    check("clr_count", 32'(count), 0);
    check("clr_idx", 32'(dut.r_idx), 0);
    check("clr_valid", 32'(instr_valid), 0);
    check("clr_opcode", 32'(opcode_o), 0);
    send(8'h12);
    push_exp(8'h12, 16'h0000, 2'd0);
    check("clr_next_count", 32'(count), 1);
    pop_check("clr_next_head", 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
